spi_slave_rx: RTL and testbench

SPI_SLAVE_RX -- requirements
Module: spi_slave_rx

---
 rtl/spi_slave_rx.sv | 173 +++++++++++++++++
 tb/tb_spi_slave_rx.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_rx.sv
// SPI mode-3 slave: synchronized receive path into a byte FIFO,
// single-byte holding register feeding MISO.
module spi_slave_rx #(
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       spi_clk_i,
  input  logic       spi_mosi_i,
  input  logic       spi_cs_i,
  output logic       spi_miso_o,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       frame_active,
  output logic       rx_overrun,
  input  logic       ovr_clr
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] fill_q;
  logic                   sclk_prev_q;
  logic                   armed_q, armed_d;

  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] rxsh_q, rxsh_d;
  logic [7:0] txsh_q, txsh_d;
  logic [7:0] hold_q, hold_d;
  logic       hold_full_q, hold_full_d;
  logic       ovr_q, ovr_d;

  logic [AW:0] wr_q, wr_d;
  logic [AW:0] rd_q, rd_d;
  logic [7:0]  mem_q [FIFO_DEPTH];

  logic       sclk_s, mosi_s, cs_s;
  logic       rise, fall, load, accept;
  logic       push, wr_en, pop, full, empty;
  logic [7:0] push_byte;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];

  assign frame_active = (state_q == ACTIVE);
  assign rise = frame_active & ~cs_s & sclk_s & ~sclk_prev_q;
  assign fall = frame_active & ~cs_s & ~sclk_s & sclk_prev_q;
  assign load = fall & (bit_cnt_q == 3'd0);

  // A load frees the holding register, so a new byte may land the same cycle.
  assign tx_ready = ~hold_full_q | load;
  assign accept   = tx_valid & tx_ready;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) &&
                 (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign rx_valid = ~empty;
  assign pop      = rx_valid & rx_ready;
  assign wr_en    = push & (~full | pop);
  assign rx_data  = rx_valid ? mem_q[rd_q[AW-1:0]] : 8'h00;

  assign spi_miso_o = frame_active ? txsh_q[7] : 1'b1;
  assign rx_overrun = ovr_q;

  always_comb begin
    state_d     = state_q;
    armed_d     = armed_q;
    bit_cnt_d   = bit_cnt_q;
    rxsh_d      = rxsh_q;
    txsh_d      = txsh_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    ovr_d       = ovr_q;
    wr_d        = wr_q;
    rd_d        = rd_q;
    push        = 1'b0;
    push_byte   = {rxsh_q[6:0], mosi_s};

    // Arm only once a genuine CS-high sample has crossed the synchronizer.
    if (fill_q[SYNC_STAGES-1] && cs_s) armed_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        bit_cnt_d = 3'd0;
        txsh_d    = 8'hFF;
        if (!cs_s && armed_q) state_d = ACTIVE;
      end
      ACTIVE: begin
        if (cs_s) begin
          state_d   = IDLE;
          bit_cnt_d = 3'd0;
        end else begin
          if (rise) begin
            rxsh_d    = push_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            push      = (bit_cnt_q == 3'd7);
          end
          if (load) begin
            txsh_d = hold_full_q ? hold_q : 8'hFF;
          end else if (fall) begin
            txsh_d = {txsh_q[6:0], 1'b1};
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) hold_full_d = 1'b0;
    if (accept) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end

    if (wr_en) wr_d = wr_q + 1'b1;
    if (pop)   rd_d = rd_q + 1'b1;

    if (push && full && !pop) ovr_d = 1'b1;
    else if (ovr_clr)         ovr_d = 1'b0;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sclk_sync_q <= '1;
      mosi_sync_q <= '0;
      cs_sync_q   <= '1;
      fill_q      <= '0;
      sclk_prev_q <= 1'b1;
      armed_q     <= 1'b0;
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      rxsh_q      <= 8'h00;
      txsh_q      <= 8'hFF;
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
      ovr_q       <= 1'b0;
      wr_q        <= '0;
      rd_q        <= '0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_clk_i};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_i};
      fill_q      <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      sclk_prev_q <= sclk_s;
      armed_q     <= armed_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rxsh_q      <= rxsh_d;
      txsh_q      <= txsh_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      ovr_q       <= ovr_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (wr_en) mem_q[wr_q[AW-1:0]] <= push_byte;
  end

endmodule

// File: tb/tb_spi_slave_rx.sv
// Bench for spi_slave_rx: bit-banged mode-3 master, expected RX bytes
// queued as they are sent and compared as the FIFO delivers them.
module tb_spi_slave_rx;

  localparam int DEPTH = 4;
  localparam int SS    = 2;
  localparam int H     = 6;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       sclk = 1'b1;
  logic       mosi = 1'b0;
  logic       cs = 1'b1;
  logic       miso;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       frame_active;
  logic       rx_overrun;
  logic       ovr_clr = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  spi_slave_rx #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(SS)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .spi_clk_i(sclk), .spi_mosi_i(mosi), .spi_cs_i(cs),
    .spi_miso_o(miso),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .frame_active(frame_active), .rx_overrun(rx_overrun),
    .ovr_clr(ovr_clr)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic spi_byte(input logic [7:0] m, input int nb,
                          output logic [7:0] s, output int lat);
    s = 8'h00;
    lat = -1;
    for (int b = 0; b < nb; b++) begin
      @(negedge sys_clk);
      sclk = 1'b0;
      mosi = m[7-b];
      repeat (H) @(negedge sys_clk);
      sclk = 1'b1;
      s[7-b] = miso;
      for (int k = 1; k <= H; k++) begin
        @(negedge sys_clk);
        if (lat < 0 && rx_valid) lat = k;
      end
    end
  endtask

  task automatic cs_set(input logic v);
    @(negedge sys_clk);
    cs = v;
    repeat (H) @(negedge sys_clk);
  endtask

  task automatic send_tx(input logic [7:0] d);
    @(negedge sys_clk);
    tx_data = d;
    tx_valid = 1'b1;
    @(negedge sys_clk);
    tx_valid = 1'b0;
  endtask

  task automatic pop_byte(output logic ok, output logic [7:0] d);
    ok = 1'b0;
    d = 8'h00;
    for (int i = 0; i < 50; i++) begin
      @(negedge sys_clk);
      if (rx_valid) begin
        d = rx_data;
        ok = 1'b1;
        rx_ready = 1'b1;
        @(negedge sys_clk);
        rx_ready = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (rx_valid !== 1'b0 || rx_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_rx: valid=%b data=%h need 0/00", rx_valid, rx_data);
    end
    checks++;
    if (tx_ready !== 1'b1 || miso !== 1'b1) begin
      errors++;
      $display("FAIL reset_tx: ready=%b miso=%b need 1/1", tx_ready, miso);
    end
    checks++;
    if (frame_active !== 1'b0 || rx_overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: fa=%b ovr=%b need 0/0",
               frame_active, rx_overrun);
    end
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    repeat (5) @(negedge sys_clk);
  endtask

  task automatic test_single();
    logic [7:0] s, d;
    logic ok;
    int lat;
    send_tx(8'h3C);
    checks++;
    if (tx_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_txfull: tx_ready=%b need 0", tx_ready);
    end
    cs_set(1'b0);
    checks++;
    if (frame_active !== 1'b1) begin
      errors++;
      $display("FAIL single_active: frame_active=%b need 1", frame_active);
    end
    exp_q.push_back(8'hA5);
    spi_byte(8'hA5, 8, s, lat);
    checks++;
    if (s !== 8'h3C) begin
      errors++;
      $display("FAIL single_miso: got %h need 3c", s);
    end
    checks++;
    if (lat < 1 || lat > SS + 2) begin
      errors++;
      $display("FAIL single_latency: got %0d need 1..%0d", lat, SS + 2);
    end
    cs_set(1'b1);
    pop_byte(ok, d);
    checks++;
    if (!ok || d !== exp_q[0]) begin
      errors++;
      $display("FAIL single_rx: ok=%b data=%h need %h", ok, d, exp_q[0]);
    end
    void'(exp_q.pop_front());
  endtask

  task automatic test_underrun();
    logic [7:0] s, d;
    logic ok;
    int lat;
    cs_set(1'b0);
    exp_q.push_back(8'h5A);
    spi_byte(8'h5A, 8, s, lat);
    checks++;
    if (s !== 8'hFF || tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL underrun_miso: miso=%h ready=%b need ff/1", s, tx_ready);
    end
    cs_set(1'b1);
    pop_byte(ok, d);
    checks++;
    if (!ok || d !== exp_q[0]) begin
      errors++;
      $display("FAIL underrun_rx: ok=%b data=%h need %h", ok, d, exp_q[0]);
    end
    void'(exp_q.pop_front());
  endtask

  task automatic test_overflow();
    logic [7:0] s, d;
    logic ok;
    int lat;
    cs_set(1'b0);
    for (int i = 1; i <= DEPTH + 1; i++) begin
      if (i <= DEPTH) exp_q.push_back(8'(i));
      spi_byte(8'(i), 8, s, lat);
    end
    cs_set(1'b1);
    checks++;
    if (rx_overrun !== 1'b1) begin
      errors++;
      $display("FAIL ovf_flag: rx_overrun=%b need 1", rx_overrun);
    end
    while (exp_q.size() > 0) begin
      pop_byte(ok, d);
      checks++;
      if (!ok || d !== exp_q[0]) begin
        errors++;
        $display("FAIL ovf_rx: ok=%b data=%h need %h", ok, d, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
    @(negedge sys_clk);
    checks++;
    if (rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL ovf_empty: rx_valid=%b need 0", rx_valid);
    end
    ovr_clr = 1'b1;
    @(negedge sys_clk);
    ovr_clr = 1'b0;
    checks++;
    if (rx_overrun !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clr: rx_overrun=%b need 0", rx_overrun);
    end
  endtask

  task automatic test_abort();
    logic [7:0] s, d;
    logic ok;
    int lat;
    cs_set(1'b0);
    spi_byte(8'hFF, 5, s, lat);
    cs_set(1'b1);
    checks++;
    if (frame_active !== 1'b0 || miso !== 1'b1 || rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_state: fa=%b miso=%b valid=%b need 0/1/0",
               frame_active, miso, rx_valid);
    end
    cs_set(1'b0);
    exp_q.push_back(8'hC3);
    spi_byte(8'hC3, 8, s, lat);
    cs_set(1'b1);
    pop_byte(ok, d);
    checks++;
    if (!ok || d !== exp_q[0]) begin
      errors++;
      $display("FAIL abort_rx: ok=%b data=%h need %h", ok, d, exp_q[0]);
    end
    void'(exp_q.pop_front());
  endtask

  task automatic test_back_to_back();
    logic [7:0] s, d;
    logic [7:0] txb[3];
    logic [7:0] rxb[3];
    logic ok;
    int lat;
    txb[0] = 8'h81; txb[1] = 8'h7E; txb[2] = 8'hD2;
    rxb[0] = 8'h11; rxb[1] = 8'hE4; rxb[2] = 8'h69;
    send_tx(txb[0]);
    cs_set(1'b0);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(rxb[i]);
      spi_byte(rxb[i], 8, s, lat);
      checks++;
      if (s !== txb[i]) begin
        errors++;
        $display("FAIL b2b_miso%0d: got %h need %h", i, s, txb[i]);
      end
      if (i < 2) send_tx(txb[i+1]);
    end
    cs_set(1'b1);
    while (exp_q.size() > 0) begin
      pop_byte(ok, d);
      checks++;
      if (!ok || d !== exp_q[0]) begin
        errors++;
        $display("FAIL b2b_rx: ok=%b data=%h need %h", ok, d, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_reset_mid_byte();
    logic [7:0] s, d;
    logic ok;
    int lat;
    send_tx(8'h42);
    cs_set(1'b0);
    spi_byte(8'hF0, 4, s, lat);
    @(negedge sys_clk);
    sys_rst = 1'b1;
    #1;
    checks++;
    if (rx_valid !== 1'b0 || rx_data !== 8'h00 || tx_ready !== 1'b1 ||
        miso !== 1'b1 || frame_active !== 1'b0 || rx_overrun !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_outputs: v=%b d=%h tr=%b miso=%b fa=%b ovr=%b",
               rx_valid, rx_data, tx_ready, miso, frame_active, rx_overrun);
    end
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    spi_byte(8'h0F, 8, s, lat);
    checks++;
    if (frame_active !== 1'b0 || rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_cs_low_ignored: fa=%b valid=%b need 0/0",
               frame_active, rx_valid);
    end
    cs_set(1'b1);
    cs_set(1'b0);
    exp_q.push_back(8'h96);
    spi_byte(8'h96, 8, s, lat);
    cs_set(1'b1);
    pop_byte(ok, d);
    checks++;
    if (!ok || d !== exp_q[0]) begin
      errors++;
      $display("FAIL rstmid_rx: ok=%b data=%h need %h", ok, d, exp_q[0]);
    end
    void'(exp_q.pop_front());
  endtask

  initial begin
    test_reset();
    test_single();
    test_underrun();
    test_overflow();
    test_abort();
    test_back_to_back();
    test_reset_mid_byte();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
